// File: rtl/bin_to_gray_stream_pkg.sv
// Shared types and helpers for the binary-to-Gray streaming encoder.
// Entries are sized for the widest legal configuration; narrower tops zero-extend.
package bin_to_gray_stream_pkg;

  localparam int unsigned WidthDefault = 8;
  localparam int unsigned MaxWidth     = 16;

  typedef struct packed {
    logic [MaxWidth-1:0] bin;
    logic [MaxWidth-1:0] gray;
    logic                wrap;
  } entry_t;

  function automatic logic [MaxWidth-1:0] gray_enc(input logic [MaxWidth-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_skid_buf.sv
// Two-entry in-order buffer with registered head output.
// Accepts a push while full as long as the head is popped in the same cycle.
module gray_skid_buf #(
  parameter int unsigned EntryW = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [EntryW-1:0] data_i,
  output logic              space_o,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [EntryW-1:0] data_o
);

  logic [1:0]        count_q, count_d;
  logic [EntryW-1:0] head_q, head_d;
  logic [EntryW-1:0] tail_q, tail_d;
  logic              pop_ok, push_ok;

  assign valid_o = (count_q != 2'd0);
  assign pop_ok  = pop_i & valid_o;
  assign space_o = (count_q != 2'd2) | pop_ok;
  assign push_ok = push_i & space_o;
  assign data_o  = head_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10: begin
        if (count_q == 2'd0) head_d = data_i;
        else                 tail_d = data_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; the new entry lands behind whatever remains.
        if (count_q == 2'd1) begin
          head_d = data_i;
        end else begin
          head_d = tail_q;
          tail_d = data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/bin_to_gray_stream.sv
// Streaming binary-to-Gray encoder fed either by an input stream or an internal counter.
// Source selection, counter and encoding live here; buffering is in gray_skid_buf.
module bin_to_gray_stream
  import bin_to_gray_stream_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bin,
  input  logic             count_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gray,
  output logic [WIDTH-1:0] out_bin,
  output logic             out_wrap
);

  logic                space;
  logic                in_xfer, cnt_push, push;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [MaxWidth-1:0] src_bin;
  entry_t              din, dout;

  assign in_ready = ~mode & space;
  assign in_xfer  = in_valid & in_ready;
  assign cnt_push = mode & count_en & space;
  assign push     = in_xfer | cnt_push;

  always_comb begin
    src_bin = '0;
    src_bin[WIDTH-1:0] = mode ? cnt_q : in_bin;
    din.bin  = src_bin;
    din.gray = gray_enc(src_bin);
    din.wrap = mode & (&cnt_q);
    cnt_d    = cnt_push ? cnt_q + WIDTH'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  gray_skid_buf #(
    .EntryW ($bits(entry_t))
  ) u_buf (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .data_i  (din),
    .space_o (space),
    .pop_i   (out_ready),
    .valid_o (out_valid),
    .data_o  (dout)
  );

  assign out_bin  = dout.bin[WIDTH-1:0];
  assign out_gray = dout.gray[WIDTH-1:0];
  assign out_wrap = dout.wrap;

  if (WIDTH < MaxWidth) begin : g_pad
    logic unused_hi;
    assign unused_hi = ^{dout.bin[MaxWidth-1:WIDTH], dout.gray[MaxWidth-1:WIDTH]};
  end

endmodule

// File: doc/bin_to_gray_stream.md
BIN_TO_GRAY_STREAM -- requirements
Module: bin_to_gray_stream

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port mode, input, 1 bit: 0 = convert input stream, 1 = internal counter source.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_bin is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts in_bin this cycle.
REQ-007 The block SHALL have port in_bin, input, WIDTH bits: binary value to encode.
REQ-008 The block SHALL have port count_en, input, 1 bit: in counter mode, request one counter push this cycle.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_gray, out_bin and out_wrap are valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the output this cycle.
REQ-011 The block SHALL have port out_gray, output, WIDTH bits: Gray code of out_bin.
REQ-012 The block SHALL have port out_bin, output, WIDTH bits: binary source value of the current output entry.
REQ-013 The block SHALL have port out_wrap, output, 1 bit: the current entry is the counter's all-ones value.

Function
REQ-014 The Gray encoding SHALL be gray = bin XOR (bin >> 1), logical shift, WIDTH bits wide.
REQ-015 The block SHALL hold a 2-entry in-order output buffer; each entry holds {bin, gray, wrap}.
REQ-016 An input transfer SHALL occur when in_valid and in_ready are both high; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-017 in_ready SHALL be high when mode=0 and the buffer holds fewer than 2 entries, or holds 2 entries and an output transfer occurs this cycle; in_ready SHALL be low when mode=1.
REQ-018 The latency SHALL be one cycle: a value accepted in cycle N into an empty buffer SHALL drive out_valid high with its encoding in cycle N+1.
REQ-019 out_valid SHALL equal "buffer non-empty"; outputs SHALL be registered and SHALL come from the oldest entry.
REQ-020 While out_valid is high and out_ready is low, out_gray, out_bin and out_wrap SHALL stay stable.
REQ-021 When an input transfer and an output transfer occur in the same cycle, the occupancy SHALL be unchanged and order SHALL be preserved; at full buffer this sustains one transfer per cycle.
REQ-022 An input transfer SHALL write wrap=0.
REQ-023 In counter mode, a push SHALL occur when count_en is high and the push-space condition of REQ-017 (mode ignored) holds; the push SHALL enqueue {cnt, gray(cnt), cnt==all-ones}.
REQ-024 The counter cnt (WIDTH bits) SHALL increment modulo 2^WIDTH on each push, wrap from all-ones to 0, and otherwise hold, including while mode=0.
REQ-025 A mode change SHALL take effect in the same cycle; entries already buffered SHALL drain unchanged and in order.
REQ-026 When the buffer is full and there is no output transfer, count_en SHALL be ignored and cnt SHALL hold.

Reset
REQ-027 While rst is high at a clock edge, the block SHALL empty the buffer, set cnt=0 and ignore all inputs; this also applies mid-transfer.
REQ-028 In the cycle after reset, out_valid, out_wrap, out_gray and out_bin SHALL be 0, and in_ready SHALL be 1 if mode=0.

Structure
REQ-029 A shared package SHALL hold the WIDTH default constant, the Gray-encode function and the buffer-entry struct typedef.
REQ-030 The 2-entry buffer SHALL be a sub-module named gray_skid_buf, parameterised by the entry type width; the top SHALL contain source selection, the counter and the encoding.

Verification
REQ-031 Scenario: mode=0, out_ready=1, in_bin 0x05, 0x08, 0xFF on consecutive cycles -> out_gray 0x07, 0x0C, 0x80 on the following consecutive cycles, out_wrap=0.
REQ-032 Scenario: out_ready=0, push 0x01, 0x02, 0x03 -> in_ready drops after 2 accepts; raising out_ready yields 0x01, 0x03 (gray of 1, 2) in order, then accepts 0x03 -> 0x02.
REQ-033 Scenario: mode=1, count_en=1, out_ready=1 from reset -> out_gray sequence 0x00, 0x01, 0x03, 0x02, 0x06, 0x07, 0x05, 0x04.
REQ-034 Scenario: WIDTH=8, counter at 0xFE, two pushes -> entries bin 0xFE / gray 0x81 / wrap 0, then bin 0xFF / gray 0x80 / wrap 1; next push is bin 0x00 / wrap 0.
REQ-035 Scenario: buffer full with cnt=5, assert rst for one cycle mid-stream -> next cycle out_valid=0 and buffer empty; next counter push emits bin 0x00.
REQ-036 Scenario: switch mode 0->1 with one input entry buffered -> that entry emerges first, then counter values, with no loss or duplication.
